mitchell_sched: RTL
===================

MITCHELL_SCHED -- requirements
Module: mitchell_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 SHALL have parameter OP_W, default 9, operand width; only OP_W-1 LSBs carry magnitude (0..255).
REQ-003 SHALL have parameter P_W, default 17, product width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have req_valid  in  N_REQ  per-requester operand valid.
REQ-007 SHALL have req_ready  out  N_REQ  per-requester accept, at most one bit set.
REQ-008 SHALL have req_x, req_y  in  N_REQ*OP_W  packed operands, requester i at bits [i*OP_W +: OP_W].
REQ-009 SHALL have cfg_exact  in  N_REQ  per-requester mode: 1 = exact product, 0 = Mitchell product.
REQ-010 SHALL have resp_valid  out  1, resp_ready  in  1, resp_id  out  clog2(N_REQ), resp_p  out  P_W.
REQ-011 SHALL have done_cnt  out  32  count of completed responses.

Function
REQ-012 SHALL arbitrate round-robin: search starts at pointer rr_ptr, ascending modulo N_REQ; first requester with req_valid wins.
REQ-013 SHALL advance rr_ptr to (winner+1) mod N_REQ only on an accepted transfer (req_valid & req_ready); otherwise rr_ptr holds.
REQ-014 SHALL assert req_ready[i] only for the winner, and only when stage S1 is empty or advancing in that cycle.
REQ-015 SHALL implement two stages: S1 registers x, y, id, exact flag (sampled from cfg_exact at accept); S2 registers product, id.
REQ-016 SHALL compute the S2 product from S1 registers: exact mode -> x*y; Mitchell mode -> output of the shared MITCHEL instance.
REQ-017 SHALL force product 0 when either S1 operand is 0, in both modes.
REQ-018 SHALL give latency 2: accept on edge t -> resp_valid high after edge t+2 when resp_ready is held high.
REQ-019 SHALL sustain throughput of one accept per cycle with resp_ready high.
REQ-020 SHALL advance S2 when S2 is empty or resp_ready=1; S1 advances when S1 is empty or S2 advances.
REQ-021 SHALL hold resp_valid, resp_id and resp_p stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL increment done_cnt by 1 on each resp_valid & resp_ready cycle; wraps from 2^32-1 to 0.
REQ-023 SHALL accept a new request in the same cycle that S2 drains, with no bubble inserted.
REQ-024 SHALL take cfg_exact changes only at accept; in-flight operations keep their sampled mode.

Reset
REQ-025 SHALL on rst_n=0 immediately clear S1/S2 valid, rr_ptr, done_cnt, resp_valid, resp_id and resp_p to 0, and drive req_ready to 0.
REQ-026 SHALL drop in-flight operations on mid-operation reset; none SHALL be emitted after release.
REQ-027 SHALL accept requests from the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place N_REQ, OP_W, P_W defaults and the requester-id typedef in shared package mitchell_sched_pkg.
REQ-029 SHALL implement arbitration as sub-module rr_arbiter (request vector, pointer, advance strobe -> one-hot grant).
REQ-030 SHALL instantiate the existing MITCHEL multiplier exactly once (ports x, y, p) as the shared datapath.

Verification
REQ-031 SHALL cover: requester 0 only, x=3, y=3, cfg_exact=0 -> resp_p=8, resp_id=0, two cycles after accept; with cfg_exact=1 -> resp_p=9.
REQ-032 SHALL cover: x=255, y=255 -> Mitchell resp_p=65024; exact resp_p=65025; x=0, y=200 -> resp_p=0 in both modes.
REQ-033 SHALL cover: all four requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0,…; one response per cycle; done_cnt=8 after 8 responses.
REQ-034 SHALL cover: resp_ready=0 for 5 cycles with 3 requests pending -> two held in S1/S2, req_ready all 0, resp_* stable; on release -> responses in accept order, no loss or duplication.
REQ-035 SHALL cover: rst_n pulsed low while S1 and S2 are full -> resp_valid=0 immediately, done_cnt=0, no stale response after release.
REQ-036 SHALL cover: random traffic of 10^6 operands (0..255), random resp_ready -> every response matches a scoreboard model, and the Mitchell-mode mean relative error is reported.

Source files
------------

// File: rtl/mitchell_sched_pkg.sv
// Shared defaults and requester-id type for the Mitchell multiplier scheduler.
`default_nettype none

package mitchell_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int OP_W_DEF  = 9;
  localparam int P_W_DEF   = 17;

  // Keeps a one-bit id field legal even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);

  typedef logic [ID_W_DEF-1:0] req_id_t;

endpackage

`default_nettype wire

// File: rtl/MITCHEL.sv
// Mitchell logarithmic multiplier: p ~= x*y via leading-one position plus linear mantissa.
`default_nettype none

module MITCHEL #(
  parameter int W = 8
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW:0] C_FRAC_BITS = (KW+1)'(W-1);

  function automatic logic [KW-1:0] lead_one(input logic [W-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Fraction below the leading one, left-aligned to W-1 bits.
  function automatic logic [W-2:0] frac(input logic [W-1:0] v, input logic [KW-1:0] k);
    return (W-1)'(v << (KW'(W-1) - k));
  endfunction

  logic [KW-1:0]  kx, ky;
  logic [W-2:0]   fx, fy;
  logic [W-1:0]   fsum;
  logic           carry;
  logic [W-1:0]   mant;
  logic [KW:0]    shamt;
  logic [2*W-1:0] ext;

  assign kx    = lead_one(x);
  assign ky    = lead_one(y);
  assign fx    = frac(x, kx);
  assign fy    = frac(y, ky);
  assign fsum  = {1'b0, fx} + {1'b0, fy};
  assign carry = fsum[W-1];

  // Fraction sum >= 1 moves into the next octave: 2^(kx+ky+1) * (fx+fy).
  assign mant  = carry ? fsum : {1'b1, fsum[W-2:0]};
  assign shamt = {1'b0, kx} + {1'b0, ky} + {{KW{1'b0}}, carry};
  assign ext   = {{W{1'b0}}, mant};

  always_comb begin
    p = '0;
    if (shamt >= C_FRAC_BITS) begin
      p = ext << (shamt - C_FRAC_BITS);
    end else begin
      p = ext >> (C_FRAC_BITS - shamt);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mitchell_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from ptr; ptr moves past the winner on advance.
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] ptr;

  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IW'(N-1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mitchell_sched.sv
// Shares one Mitchell/exact multiplier among N_REQ requesters through a two-stage pipeline.
`default_nettype none

module mitchell_sched
  import mitchell_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int P_W   = P_W_DEF,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_x,
  input  logic [N_REQ*OP_W-1:0] req_y,
  input  logic [N_REQ-1:0]      cfg_exact,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [P_W-1:0]        resp_p,
  output logic [31:0]           done_cnt
);

  localparam int MW = OP_W - 1;

  logic            s1_v, s2_v;
  logic [MW-1:0]   s1_x, s1_y;
  logic [ID_W-1:0] s1_id;
  logic            s1_exact;

  logic            s1_adv, s2_adv, accept;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic [MW-1:0]   sel_x, sel_y;
  logic            sel_exact;

  logic [2*MW-1:0] mitch_p, exact_p;
  logic [P_W-1:0]  prod;

  // The operand MSB carries no magnitude.
  logic [N_REQ-1:0] unused_op_msb;
  for (genvar i = 0; i < N_REQ; i++) begin : g_op_msb
    assign unused_op_msb[i] = req_x[i*OP_W+MW] ^ req_y[i*OP_W+MW];
  end

  assign s2_adv    = !s2_v || resp_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign req_ready = (rst_n && s1_adv) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_x     = req_x[int'(grant_id)*OP_W +: MW];
  assign sel_y     = req_y[int'(grant_id)*OP_W +: MW];
  assign sel_exact = cfg_exact[grant_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_id    <= '0;
      s1_exact <= 1'b0;
    end else if (accept) begin
      s1_v     <= 1'b1;
      s1_x     <= sel_x;
      s1_y     <= sel_y;
      s1_id    <= grant_id;
      s1_exact <= sel_exact;
    end else if (s1_adv) begin
      s1_v     <= 1'b0;
    end
  end

  MITCHEL #(
    .W (MW)
  ) u_mitchel (
    .x (s1_x),
    .y (s1_y),
    .p (mitch_p)
  );

  assign exact_p = {{MW{1'b0}}, s1_x} * {{MW{1'b0}}, s1_y};

  // Mitchell has no encoding for zero, so a zero operand is forced here for both modes.
  always_comb begin
    prod = '0;
    if (s1_x != '0 && s1_y != '0) begin
      prod = s1_exact ? P_W'(exact_p) : P_W'(mitch_p);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      resp_id <= '0;
      resp_p  <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        resp_id <= s1_id;
        resp_p  <= prod;
      end
    end
  end

  assign resp_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (s2_v && resp_ready) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
